// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared funct3 encodings, FSM state type and request decode
//            helpers for the lsu_rmw load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

   // RISC-V load/store funct3 encodings (stores reuse B/H/W)
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_RMW_RD = 3'd2,
      S_WRITE  = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   // Stores only have B/H/W; loads additionally have the unsigned forms
   function automatic logic f3_legal(input logic write, input logic [2:0] f3);
      logic ok;
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (!write && ((f3 == F3_BU) || (f3 == F3_HU))) ok = 1'b1;
      return ok;
   endfunction

   // Natural-alignment violation for the access size encoded in funct3
   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      if ((f3 == F3_H) || (f3 == F3_HU)) mis = off[0];
      if (f3 == F3_W)                    mis = (off != 2'b00);
      return mis;
   endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane
// Purpose  : Combinational lane logic: extracts/extends a load lane from a
//            RAM word and merges store data into a RAM word. Halfword lane
//            is chosen by offset[1] only; word accesses ignore the offset.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Select the addressed lane and sign/zero-extend it for loads
   always_comb begin
      lane_b    = word[{offset, 3'b000} +: 8];
      lane_h    = word[{offset[1], 4'b0000} +: 16];
      load_data = word;
      case (funct3)
         F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
         F3_BU:   load_data = {24'h0, lane_b};
         F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
         F3_HU:   load_data = {16'h0, lane_h};
         default: load_data = word;
      endcase
   end

   // Overwrite only the addressed byte/halfword, leaving other lanes intact
   always_comb begin
      merged = word;
      case (funct3[1:0])
         2'b00:   merged[{offset, 3'b000} +: 8]     = wdata[7:0];
         2'b01:   merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
         default: merged = wdata;
      endcase
   end

endmodule : lsu_lane
`default_nettype wire

// File: rtl/lsu_rmw.sv
`default_nettype none
// ============================================================================
// Module   : lsu_rmw
// Purpose  : Single-outstanding load/store unit in front of a word-write
//            byte-array RAM. Sub-word stores become read-modify-write.
//            Optional build macro LSU_ALIGN_CHECK_EN turns misaligned
//            halfword/word accesses into error responses; without it the
//            low address bits are ignored for those sizes.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_rmw
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_error,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [2:0]            funct3_q;
   logic [31:0]           wdata_q;
   logic [31:0]           merge_q;
   logic [31:0]           resp_rdata_q;
   logic                  resp_valid_q;
   logic                  resp_error_q;

   logic                  req_err;
   logic [31:0]           lane_load;
   logic [31:0]           lane_merged;

`ifdef LSU_ALIGN_CHECK_EN
   assign req_err = !f3_legal(req_write, req_funct3) ||
                    f3_misaligned(req_funct3, req_addr[1:0]);
`else
   assign req_err = !f3_legal(req_write, req_funct3);
`endif

   lsu_lane u_lane (
      .word      (mem_rdata),
      .offset    (addr_q[1:0]),
      .funct3    (funct3_q),
      .wdata     (wdata_q),
      .load_data (lane_load),
      .merged    (lane_merged)
   );

   // State-decoded strobes; the write strobe is killed by reset so a reset
   // landing on the WRITE cycle never commits a partially built word.
   assign req_ready   = (state_q == S_IDLE);
   assign mem_read    = (state_q == S_LOAD) || (state_q == S_RMW_RD);
   assign mem_write   = (state_q == S_WRITE) && !rst;
   assign mem_address = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign mem_wdata   = merge_q;
   assign resp_valid  = resp_valid_q;
   assign resp_rdata  = resp_rdata_q;
   assign resp_error  = resp_error_q;

   // Request sequencing FSM with registered response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         funct3_q     <= 3'b000;
         wdata_q      <= 32'h0;
         merge_q      <= 32'h0;
         resp_rdata_q <= 32'h0;
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  addr_q       <= req_addr;
                  funct3_q     <= req_funct3;
                  wdata_q      <= req_wdata;
                  resp_rdata_q <= 32'h0;
                  resp_error_q <= 1'b0;
                  if (req_err) begin
                     resp_error_q <= 1'b1;
                     resp_valid_q <= 1'b1;
                     state_q      <= S_RESP;
                  end else if (!req_write) begin
                     state_q <= S_LOAD;
                  end else if (req_funct3 == F3_W) begin
                     // Full word needs no read; it goes straight to the write port
                     merge_q <= req_wdata;
                     state_q <= S_WRITE;
                  end else begin
                     state_q <= S_RMW_RD;
                  end
               end
            end
            S_LOAD: begin
               resp_rdata_q <= lane_load;
               resp_valid_q <= 1'b1;
               state_q      <= S_RESP;
            end
            S_RMW_RD: begin
               merge_q <= lane_merged;
               state_q <= S_WRITE;
            end
            S_WRITE: begin
               resp_valid_q <= 1'b1;
               state_q      <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  resp_error_q <= 1'b0;
                  resp_rdata_q <= 32'h0;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule : lsu_rmw
`default_nettype wire

// File: tb/tb_lsu_rmw.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_rmw
// Purpose  : Self-checking bench for lsu_rmw against a byte-level memory
//            model. Honors LSU_ALIGN_CHECK_EN when computing expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_rmw;

   localparam int RAM_BYTES = 4096;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int checks   = 0;
   int failures = 0;

   // Word RAM seen by the DUT plus a bench-side loader port
   logic [31:0] ram [RAM_BYTES/4];
   logic        ld_en;
   logic [9:0]  ld_idx;
   logic [31:0] ld_data;

   // Reference memory, byte granular
   logic [7:0]  ref_mem [RAM_BYTES];

   lsu_rmw #(.ADDR_WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_funct3  (req_funct3),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_rdata  (resp_rdata),
      .resp_error  (resp_error),
      .mem_address (mem_address),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = (mem_address < RAM_BYTES) ? ram[mem_address[11:2]] : 32'h0;

   // RAM write port: bench preload has priority over DUT writes
   always @(posedge clk) begin
      if (ld_en) ram[ld_idx] <= ld_data;
      else if (mem_write && (mem_address < RAM_BYTES)) ram[mem_address[11:2]] <= mem_wdata;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      return (a < RAM_BYTES) ? ref_mem[a[11:0]] : 8'h00;
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      logic [31:0] b;
      b = a & ~32'h3;
      return {ref_rd(b + 3), ref_rd(b + 2), ref_rd(b + 1), ref_rd(b)};
   endfunction

   // Preload one word into both RAM and model (call at negedge, DUT idle)
   task automatic set_word(input logic [31:0] a, input logic [31:0] v);
      ld_en = 1'b1; ld_idx = a[11:2]; ld_data = v;
      for (int k = 0; k < 4; k++) ref_mem[{a[11:2], 2'b00} + k] = v[8*k +: 8];
      @(posedge clk); @(negedge clk);
      ld_en = 1'b0;
   endtask

   // One complete transaction; expectations come from the byte model
   task automatic txn(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int hold, input bit early,
                      output logic [31:0] got);
      int          lat, nrd, nwr, size, exp_lat;
      logic        legal, err;
      logic [31:0] exp_data, base, wmask;

      legal = wr ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                 : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      err   = !legal;
`ifdef LSU_ALIGN_CHECK_EN
      if (legal && ((a % size) != 0)) err = 1'b1;
`endif
      base     = a - (a % size);
      exp_data = 32'h0;
      if (!err && !wr) begin
         for (int k = 0; k < size; k++) exp_data |= {24'h0, ref_rd(base + k)} << (8 * k);
         if (!f3[2] && size < 4 && exp_data[8*size-1]) begin
            wmask    = (32'h1 << (8 * size)) - 1;
            exp_data = exp_data | ~wmask;
         end
      end
      exp_lat = err ? 1 : (wr && f3 != 3'd2) ? 3 : 2;

      check("req_ready_idle", {31'h0, req_ready}, 32'h1);
      req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
      resp_ready = early;
      lat = 1; nrd = 0; nwr = 0;
      while (!resp_valid && lat < 10) begin
         if (mem_read)  nrd++;
         if (mem_write) nwr++;
         check("strobe_excl", {31'h0, mem_read && mem_write}, 32'h0);
         if (mem_read || mem_write) check("mem_address", mem_address, a & ~32'h3);
         @(posedge clk); @(negedge clk);
         lat++;
      end
      if (hold > 0) resp_ready = 1'b0;
      check("latency",    lat, exp_lat);
      check("resp_error", {31'h0, resp_error}, {31'h0, err});
      check("resp_rdata", resp_rdata, exp_data);
      check("read_count",  nrd, (!err && (!wr || f3 != 3'd2)) ? 1 : 0);
      check("write_count", nwr, (!err && wr) ? 1 : 0);
      got = resp_rdata;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); @(negedge clk);
         check("hold_valid", {31'h0, resp_valid}, 32'h1);
         check("hold_rdata", resp_rdata, exp_data);
         check("hold_ready", {31'h0, req_ready}, 32'h0);
      end
      resp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      resp_ready = 1'b0;
      check("resp_done_valid", {31'h0, resp_valid}, 32'h0);
      check("resp_done_ready", {31'h0, req_ready}, 32'h1);
      if (!err && wr)
         for (int k = 0; k < size; k++)
            if (base + k < RAM_BYTES) ref_mem[(base + k) & 32'hFFF] = wd[8*k +: 8];
      if (a < RAM_BYTES) check("ram_word", ram[a[11:2]], ref_word(a));
   endtask

   logic [31:0] g;
   logic [31:0] ra;

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
      ld_en = 1'b0; ld_idx = 10'h0; ld_data = 32'h0;
      @(negedge clk);
      for (int i = 0; i < RAM_BYTES / 4; i++) set_word(i * 4, $urandom);
      set_word(32'h100, 32'h80FF7F01);

      // Reset state, sampled while rst is still high
      check("rst_resp_valid",  {31'h0, resp_valid}, 32'h0);
      check("rst_resp_error",  {31'h0, resp_error}, 32'h0);
      check("rst_resp_rdata",  resp_rdata, 32'h0);
      check("rst_mem_read",    {31'h0, mem_read},  32'h0);
      check("rst_mem_write",   {31'h0, mem_write}, 32'h0);
      check("rst_mem_address", mem_address, 32'h0);
      check("rst_mem_wdata",   mem_wdata, 32'h0);
      rst = 1'b0;
      #1 check("rst_req_ready", {31'h0, req_ready}, 32'h1);
      @(negedge clk);

      // Loads from a known word
      txn(1'b0, 3'b000, 32'h101, 32'h0, 0, 1'b0, g); check("lb_101",  g, 32'h0000007F);
      txn(1'b0, 3'b000, 32'h102, 32'h0, 0, 1'b0, g); check("lb_102",  g, 32'hFFFFFFFF);
      txn(1'b0, 3'b100, 32'h103, 32'h0, 0, 1'b0, g); check("lbu_103", g, 32'h00000080);
      txn(1'b0, 3'b001, 32'h102, 32'h0, 0, 1'b0, g); check("lh_102",  g, 32'hFFFF80FF);

      // Stores: RMW byte, RMW halfword, full word
      set_word(32'h200, 32'h11223344);
      txn(1'b1, 3'b000, 32'h202, 32'h000000AA, 0, 1'b0, g);
      check("sb_ram", ram[32'h200 >> 2], 32'h11AA3344);
      set_word(32'h204, 32'hCAFED00D);
      txn(1'b1, 3'b001, 32'h206, 32'h0000BEEF, 0, 1'b0, g);
      check("sh_ram", ram[32'h204 >> 2], 32'hBEEFD00D);
      txn(1'b1, 3'b010, 32'h208, 32'hDEADBEEF, 0, 1'b0, g);
      check("sw_ram", ram[32'h208 >> 2], 32'hDEADBEEF);

      // Misaligned word load
      set_word(32'h300, 32'h12345678);
      txn(1'b0, 3'b010, 32'h301, 32'h0, 0, 1'b0, g);
`ifdef LSU_ALIGN_CHECK_EN
      check("lw_301", g, 32'h0);
`else
      check("lw_301", g, 32'h12345678);
`endif

      // Back-pressure, early ready, illegal funct3
      txn(1'b0, 3'b000, 32'h101, 32'h0, 5, 1'b0, g);
      txn(1'b0, 3'b101, 32'h102, 32'h0, 0, 1'b1, g); check("lhu_102", g, 32'h000080FF);
      txn(1'b0, 3'b011, 32'h100, 32'h0, 2, 1'b0, g);
      txn(1'b1, 3'b100, 32'h100, 32'h0, 0, 1'b0, g);

      // Reset landing on the WRITE cycle of an SB
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'h201; req_wdata = 32'h55;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      check("rw_in_write", {31'h0, mem_write}, 32'h1);
      rst = 1'b1;
      #1 check("rw_gated", {31'h0, mem_write}, 32'h0);
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      #1;
      check("rw_resp_valid", {31'h0, resp_valid}, 32'h0);
      check("rw_req_ready",  {31'h0, req_ready}, 32'h1);
      check("rw_ram",        ram[32'h200 >> 2], ref_word(32'h200));
      @(negedge clk);

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 7) == 0) ra = 32'h0001_0000 + $urandom_range(0, 255);
         else                           ra = $urandom_range(0, RAM_BYTES - 1);
         txn(1'($urandom), 3'($urandom), ra, $urandom,
             int'($urandom_range(0, 3)), 1'($urandom), g);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_lsu_rmw
`default_nettype wire
